// File: rtl/snax_tcdm_arbiter_if.sv
// Requester-side and memory-side TCDM signals around the round-robin arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface snax_tcdm_arbiter_if #(
  parameter int NumPorts  = 4,
  parameter int AddrWidth = 32,
  parameter int DataWidth = 64
);
  logic [NumPorts-1:0]           in_valid_i;
  logic [NumPorts-1:0]           in_ready_o;
  logic [NumPorts*AddrWidth-1:0] in_addr_i;
  logic [NumPorts-1:0]           in_write_i;
  logic [NumPorts*DataWidth-1:0] in_wdata_i;
  logic [NumPorts-1:0]           in_rvalid_o;
  logic [NumPorts*DataWidth-1:0] in_rdata_o;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic [AddrWidth-1:0]          out_addr_o;
  logic                          out_write_o;
  logic [DataWidth-1:0]          out_wdata_o;
  logic                          out_rvalid_i;
  logic [DataWidth-1:0]          out_rdata_i;
  logic                          err_o;

  modport slave (
    input  in_valid_i, in_addr_i, in_write_i, in_wdata_i,
    input  out_ready_i, out_rvalid_i, out_rdata_i,
    output in_ready_o, in_rvalid_o, in_rdata_o,
    output out_valid_o, out_addr_o, out_write_o, out_wdata_o, err_o
  );

  modport master (
    output in_valid_i, in_addr_i, in_write_i, in_wdata_i,
    output out_ready_i, out_rvalid_i, out_rdata_i,
    input  in_ready_o, in_rvalid_o, in_rdata_o,
    input  out_valid_o, out_addr_o, out_write_o, out_wdata_o, err_o
  );
endinterface

// File: rtl/snax_tcdm_arbiter.sv
// N-to-1 round-robin TCDM request arbiter; responses are routed back to the issuer
// through a fixed-latency tag pipeline, with a sticky error on response/tag mismatch.
module snax_tcdm_arbiter #(
  parameter int NumPorts   = 4,
  parameter int AddrWidth  = 32,
  parameter int DataWidth  = 64,
  parameter int RspLatency = 1
) (
  input logic                clk_i,
  input logic                rst_i,
  snax_tcdm_arbiter_if.slave bus
);
  localparam int PtrW = (NumPorts > 1) ? $clog2(NumPorts) : 1;

  logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [RspLatency-1:0] tag_valid_q, tag_valid_d;
  logic [PtrW-1:0]       tag_id_q [RspLatency];
  logic [PtrW-1:0]       tag_id_d [RspLatency];
  logic                  err_q, err_d;

  logic [PtrW-1:0] cand;
  logic [PtrW-1:0] grant;
  logic            grant_valid;
  logic            fire;
  logic            tail_valid;
  logic [PtrW-1:0] tail_id;

  // Scan from the highest offset down so the last hit is the first port at or after rr_ptr.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      cand = PtrW'((int'(rr_ptr_q) + i) % NumPorts);
      if (bus.in_valid_i[cand]) begin
        grant       = cand;
        grant_valid = 1'b1;
      end
    end
  end

  assign fire = grant_valid & bus.out_ready_i;

  always_comb begin
    bus.out_valid_o = grant_valid;
    bus.out_addr_o  = '0;
    bus.out_write_o = 1'b0;
    bus.out_wdata_o = '0;
    bus.in_ready_o  = '0;
    if (grant_valid) begin
      bus.out_addr_o        = bus.in_addr_i[grant*AddrWidth +: AddrWidth];
      bus.out_write_o       = bus.in_write_i[grant];
      bus.out_wdata_o       = bus.in_wdata_i[grant*DataWidth +: DataWidth];
      bus.in_ready_o[grant] = bus.out_ready_i;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (fire) begin
      rr_ptr_d = (grant == PtrW'(NumPorts - 1)) ? '0 : grant + 1'b1;
    end
  end

  // Tag pipeline: stage 0 captures this cycle's fire, the tail lines up with p_valid.
  always_comb begin
    tag_valid_d    = '0;
    tag_id_d       = '{default: '0};
    tag_valid_d[0] = fire;
    tag_id_d[0]    = grant;
    for (int k = 1; k < RspLatency; k++) begin
      tag_valid_d[k] = tag_valid_q[k-1];
      tag_id_d[k]    = tag_id_q[k-1];
    end
  end

  assign tail_valid = tag_valid_q[RspLatency-1];
  assign tail_id    = tag_id_q[RspLatency-1];

  always_comb begin
    bus.in_rvalid_o = '0;
    if (bus.out_rvalid_i && tail_valid) begin
      bus.in_rvalid_o[tail_id] = 1'b1;
    end
    err_d = err_q | (bus.out_rvalid_i ^ tail_valid);
  end

  assign bus.err_o = err_q;

  for (genvar gi = 0; gi < NumPorts; gi++) begin : g_rdata
    assign bus.in_rdata_o[gi*DataWidth +: DataWidth] = bus.out_rdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      tag_valid_q <= '0;
      tag_id_q    <= '{default: '0};
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tag_valid_q <= tag_valid_d;
      tag_id_q    <= tag_id_d;
      err_q       <= err_d;
    end
  end
endmodule
